// File: rtl/frame_sequencer.sv
// frame_sequencer: starts test-pattern frames into the JPEG encoder, watches the returned
// de stream for frame completion and geometry, and aborts frames that never finish.
module frame_sequencer #(
    parameter int H_ACTIVE       = 720,
    parameter int V_ACTIVE       = 480,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 524288,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   single,
    input  logic                   enc_ready,
    input  logic                   gen_de,
    input  logic                   err_clr,
    output logic                   gen_start,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_geom,
    output logic                   err_timeout
);
    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_ENC, START, ACTIVE, GAP} state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic                   de_q;
    logic [PW-1:0]          pix_q, pix_d;
    logic [LW-1:0]          line_q, line_d, line_inc;
    logic [TW-1:0]          to_q, to_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   geom_q, tmo_q, geom_set, tmo_set, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            de_q    <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            to_q    <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            geom_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            de_q    <= gen_de;
            pix_q   <= pix_d;
            line_q  <= line_d;
            to_q    <= to_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            geom_q  <= geom_set | (geom_q & ~err_clr);
            tmo_q   <= tmo_set | (tmo_q & ~err_clr);
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pix_d      = pix_q;
        line_d     = line_q;
        to_d       = to_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        geom_set   = 1'b0;
        tmo_set    = 1'b0;
        frame_done = 1'b0;
        fall       = de_q & ~gen_de;
        line_inc   = line_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (single || run) begin
                    state_d = WAIT_ENC;
                    mode_d  = single;
                end
            end
            WAIT_ENC: state_d = enc_ready ? START : WAIT_ENC;
            START: begin
                pix_d   = '0;
                line_d  = '0;
                to_d    = '0;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                to_d = to_q + 1'b1;
                // saturate so an overlong line can never wrap back onto H_ACTIVE
                if (gen_de) pix_d = (pix_q == '1) ? pix_q : pix_q + 1'b1;
                if (fall) begin
                    geom_set = (pix_q != PW'(H_ACTIVE));
                    pix_d    = '0;
                    line_d   = line_inc;
                    if (line_inc == LW'(V_ACTIVE)) begin
                        frame_done = 1'b1;
                        cnt_d      = cnt_q + 1'b1;
                        gap_d      = '0;
                        state_d    = GAP;
                    end
                end
                if (!frame_done && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                geom_set = gen_de;
                gap_d    = gap_q + 1'b1;
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = (run && !mode_q) ? WAIT_ENC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gen_start   = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign frame_cnt   = cnt_q;
    assign err_geom    = geom_q;
    assign err_timeout = tmo_q;
endmodule
